mips_cpu_mem_master: RTL and testbench

//  CPU-side Avalon-MM data master; sits directly upstream of the Avalon RAM slave.

---
 rtl/mips_cpu_mem_master.sv | 154 +++++++++++++++
 tb/tb_mips_cpu_mem_master.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_mem_master.sv
// mips_cpu_mem_master - CPU-side Avalon-MM data master for single load/store transfers.
module mips_cpu_mem_master #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cpu_req,
   input  logic [3:0]  cpu_op,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_done,
   output logic        cpu_err,
   output logic        cpu_busy,
   output logic [31:0] address,
   output logic [3:0]  byteenable,
   output logic        read,
   output logic        write,
   output logic [31:0] writedata,
   input  logic        waitrequest,
   input  logic [31:0] readdata
);

   typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

   state_t      state, state_nx;
   logic [2:0]  op_q, op_nx;
   logic [1:0]  k_q, k_nx;
   logic [31:0] cnt_q, cnt_nx;
   logic [31:0] rdata_nx, address_nx, writedata_nx;
   logic [3:0]  be_nx;
   logic        done_nx, err_nx, busy_nx, read_nx, write_nx;

   logic        req_store, req_bad, req_misaligned;
   logic [3:0]  req_be;
   logic [31:0] req_wd, lane_data, load_ext;

   // Request decode; op[1:0] encodes width (00 byte, 01 half, 11 word).
   always_comb begin
      req_store      = cpu_op[3];
      req_bad        = req_store ? !(cpu_op[2:0] inside {3'b000, 3'b001, 3'b011})
                                 :  (cpu_op[2:0] inside {3'b010, 3'b110, 3'b111});
      req_misaligned = (cpu_op[1:0] == 2'b01 && cpu_addr[0]) ||
                       (cpu_op[1:0] == 2'b11 && cpu_addr[1:0] != 2'b00);
      case (cpu_op[1:0])
         2'b00:   begin req_be = 4'b0001 << cpu_addr[1:0]; req_wd = {4{cpu_wdata[7:0]}};  end
         2'b01:   begin req_be = 4'b0011 << cpu_addr[1:0]; req_wd = {2{cpu_wdata[15:0]}}; end
         default: begin req_be = 4'b1111;                  req_wd = cpu_wdata;             end
      endcase
   end

   // Load lane extraction; op[2] selects zero extension.
   always_comb begin
      lane_data = readdata >> {k_q, 3'b000};
      case (op_q[1:0])
         2'b00:   load_ext = op_q[2] ? {24'b0, lane_data[7:0]}
                                     : {{24{lane_data[7]}}, lane_data[7:0]};
         2'b01:   load_ext = op_q[2] ? {16'b0, lane_data[15:0]}
                                     : {{16{lane_data[15]}}, lane_data[15:0]};
         default: load_ext = readdata;
      endcase
   end

   always_comb begin
      state_nx     = state;
      op_nx        = op_q;
      k_nx         = k_q;
      cnt_nx       = cnt_q;
      rdata_nx     = cpu_rdata;
      done_nx      = 1'b0;
      err_nx       = cpu_err;
      address_nx   = address;
      be_nx        = byteenable;
      writedata_nx = writedata;
      read_nx      = read;
      write_nx     = write;
      case (state)
         IDLE: begin
            if (cpu_req) begin
               op_nx = cpu_op[2:0];
               k_nx  = cpu_addr[1:0];
               if (req_bad || req_misaligned) begin
                  err_nx   = 1'b1;
                  done_nx  = 1'b1;
                  state_nx = DONE;
               end else begin
                  err_nx       = 1'b0;
                  address_nx   = {cpu_addr[31:2], 2'b00};
                  be_nx        = req_be;
                  writedata_nx = req_wd;
                  read_nx      = !req_store;
                  write_nx     = req_store;
                  state_nx     = BUS;
               end
            end
         end
         BUS: begin
            if (!waitrequest) begin
               read_nx  = 1'b0;
               write_nx = 1'b0;
               done_nx  = 1'b1;
               state_nx = DONE;
               if (read) rdata_nx = load_ext;
            end else if (TIMEOUT != 0 && cnt_q == TIMEOUT - 1) begin
               read_nx  = 1'b0;
               write_nx = 1'b0;
               done_nx  = 1'b1;
               err_nx   = 1'b1;
               state_nx = DONE;
            end else begin
               cnt_nx = cnt_q + 32'd1;
            end
         end
         default: begin
            cnt_nx   = 32'd0;
            state_nx = IDLE;
         end
      endcase
      busy_nx = (state_nx != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         op_q       <= 3'b0;
         k_q        <= 2'b0;
         cnt_q      <= 32'd0;
         cpu_rdata  <= 32'd0;
         cpu_done   <= 1'b0;
         cpu_err    <= 1'b0;
         cpu_busy   <= 1'b0;
         address    <= 32'd0;
         byteenable <= 4'd0;
         read       <= 1'b0;
         write      <= 1'b0;
         writedata  <= 32'd0;
      end else begin
         state      <= state_nx;
         op_q       <= op_nx;
         k_q        <= k_nx;
         cnt_q      <= cnt_nx;
         cpu_rdata  <= rdata_nx;
         cpu_done   <= done_nx;
         cpu_err    <= err_nx;
         cpu_busy   <= busy_nx;
         address    <= address_nx;
         byteenable <= be_nx;
         read       <= read_nx;
         write      <= write_nx;
         writedata  <= writedata_nx;
      end
   end

endmodule

// File: tb/tb_mips_cpu_mem_master.sv
// tb_mips_cpu_mem_master - table-driven bench with a small Avalon slave memory.
module tb_mips_cpu_mem_master;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cpu_req = 1'b0, cpu_req2 = 1'b0;
   logic [3:0]  cpu_op = 4'd0;
   logic [31:0] cpu_addr = 32'd0, cpu_wdata = 32'd0;
   logic        waitrequest = 1'b0, waitrequest2 = 1'b1;
   logic [31:0] readdata = 32'd0;

   logic [31:0] cpu_rdata, address, writedata;
   logic        cpu_done, cpu_err, cpu_busy, read, write;
   logic [3:0]  byteenable;
   logic [31:0] cpu_rdata2, address2, writedata2;
   logic        cpu_done2, cpu_err2, cpu_busy2, read2, write2;
   logic [3:0]  byteenable2;

   int checks = 0;
   int failures = 0;
   logic [31:0] mem [logic [31:0]];

   localparam logic [31:0] A = 32'hBFC00010;

   always #5 clk = ~clk;

   mips_cpu_mem_master dut (
      .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_op(cpu_op),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_busy(cpu_busy),
      .address(address), .byteenable(byteenable), .read(read), .write(write),
      .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata)
   );

   mips_cpu_mem_master #(.TIMEOUT(4)) dut_to (
      .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req2), .cpu_op(cpu_op),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata2),
      .cpu_done(cpu_done2), .cpu_err(cpu_err2), .cpu_busy(cpu_busy2),
      .address(address2), .byteenable(byteenable2), .read(read2), .write(write2),
      .writedata(writedata2), .waitrequest(waitrequest2), .readdata(readdata)
   );

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          wait_n;
      logic        err;
      logic [1:0]  kind;   // 0 none, 1 read, 2 write
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input string name, input logic [3:0] op, input logic [31:0] addr,
                      input logic [31:0] wdata, input int wait_n, input logic err,
                      input logic [1:0] kind, input logic [3:0] be, input logic [31:0] wd,
                      input logic [31:0] rdata);
      vec_t v;
      v.name = name; v.op = op; v.addr = addr; v.wdata = wdata; v.wait_n = wait_n;
      v.err = err; v.kind = kind; v.be = be; v.wd = wd; v.rdata = rdata;
      vecs.push_back(v);
   endtask

   task automatic run_vec(input vec_t v);
      int   cyc;
      int   stalls;
      logic seen;
      logic [31:0] widx;
      widx = {v.addr[31:2], 2'b00};
      @(negedge clk);
      cpu_req = 1'b1; cpu_op = v.op; cpu_addr = v.addr; cpu_wdata = v.wdata;
      readdata = mem.exists(widx) ? mem[widx] : 32'd0;
      @(posedge clk);
      #1 cpu_req = 1'b0;
      cyc = 0; stalls = v.wait_n; seen = 1'b0;
      forever begin
         @(negedge clk);
         if (cpu_done) break;
         if (cyc > 50) begin
            check({v.name, " timeout"}, 32'd1, 32'd0);
            break;
         end
         if (!seen) begin
            seen = 1'b1;
            check({v.name, " kind"}, {30'd0, write, read}, {30'd0, v.kind});
            check({v.name, " be"}, {28'd0, byteenable}, {28'd0, v.be});
            check({v.name, " addr"}, address, widx);
            if (v.kind == 2'd2) check({v.name, " wd"}, writedata, v.wd);
         end
         waitrequest = (stalls > 0);
         if (stalls > 0) stalls--;
         if (write && !waitrequest) begin
            logic [31:0] w;
            w = mem.exists(widx) ? mem[widx] : 32'd0;
            for (int b = 0; b < 4; b++)
               if (byteenable[b]) w[8*b +: 8] = writedata[8*b +: 8];
            mem[widx] = w;
         end
         @(posedge clk);
         cyc++;
      end
      check({v.name, " latency"}, cyc, v.err ? 32'd0 : v.wait_n + 1);
      check({v.name, " err"}, {31'd0, cpu_err}, {31'd0, v.err});
      check({v.name, " rdata"}, cpu_rdata, v.rdata);
      check({v.name, " rw low at done"}, {30'd0, read, write}, 32'd0);
      if (v.err) check({v.name, " no bus"}, {31'd0, seen}, 32'd0);
      waitrequest = 1'b0;
      @(negedge clk);
      check({v.name, " done one cycle"}, {30'd0, cpu_done, cpu_busy}, 32'd0);
   endtask

   initial begin
      mem[A] = 32'd0;
      add("SW",   4'b1011, A,      32'hFFFFFFFE, 0, 0, 2, 4'b1111, 32'hFFFFFFFE, 32'h00000000);
      add("LW",   4'b0011, A,      32'h0,        1, 0, 1, 4'b1111, 32'h0,        32'hFFFFFFFE);
      add("LHU",  4'b0101, A,      32'h0,        5, 0, 1, 4'b0011, 32'h0,        32'h0000FFFE);
      add("LH",   4'b0001, A + 2,  32'h0,        0, 0, 1, 4'b1100, 32'h0,        32'hFFFFFFFF);
      add("LB",   4'b0000, A + 1,  32'h0,        0, 0, 1, 4'b0010, 32'h0,        32'hFFFFFFFF);
      add("LBU",  4'b0100, A,      32'h0,        2, 0, 1, 4'b0001, 32'h0,        32'h000000FE);
      add("SB",   4'b1000, A + 3,  32'h12345678, 0, 0, 2, 4'b1000, 32'h78787878, 32'h000000FE);
      add("SH",   4'b1001, A + 2,  32'h0000ABCD, 1, 0, 2, 4'b1100, 32'hABCDABCD, 32'h000000FE);
      add("LW2",  4'b0011, A,      32'h0,        0, 0, 1, 4'b1111, 32'h0,        32'hABCDFFFE);
      add("LB3",  4'b0000, A + 3,  32'h0,        0, 0, 1, 4'b1000, 32'h0,        32'hFFFFFFAB);
      add("LBU2", 4'b0100, A + 2,  32'h0,        0, 0, 1, 4'b0100, 32'h0,        32'h000000CD);
      add("LWmis",4'b0011, A + 2,  32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h000000CD);
      add("SHmis",4'b1001, A + 1,  32'h1111,     0, 1, 0, 4'b0000, 32'h0,        32'h000000CD);
      add("Lbad", 4'b0010, A,      32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h000000CD);
      add("Sbad", 4'b1100, A,      32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h000000CD);
      add("LHUmis",4'b0101,A + 1,  32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h000000CD);

      #2;
      check("reset outputs", {cpu_rdata | address | writedata},  32'd0);
      check("reset flags", {24'd0, byteenable, cpu_done, cpu_err, cpu_busy, read, write}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

      // Reset while the slave is stalling a read.
      @(negedge clk);
      cpu_req = 1'b1; cpu_op = 4'b0011; cpu_addr = A; waitrequest = 1'b1;
      @(posedge clk);
      #1 cpu_req = 1'b0;
      @(posedge clk);
      #1 check("mid-bus read high", {31'd0, read}, 32'd1);
      #3 reset_n = 1'b0;
      #1 check("async reset rw/busy/done", {29'd0, read, cpu_busy, cpu_done}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      waitrequest = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("no done after reset", {31'd0, cpu_done}, 32'd0);
      end
      add("LWpost", 4'b0011, A, 32'h0, 0, 0, 1, 4'b1111, 32'h0, 32'hABCDFFFE);
      run_vec(vecs[vecs.size() - 1]);

      // TIMEOUT=4 instance with waitrequest stuck high.
      begin
         int cyc;
         logic read_before;
         @(negedge clk);
         cpu_req2 = 1'b1; cpu_op = 4'b0011; cpu_addr = A; waitrequest2 = 1'b1;
         @(posedge clk);
         #1 cpu_req2 = 1'b0;
         cyc = 0; read_before = 1'b0;
         forever begin
            @(negedge clk);
            if (cpu_done2 || cyc > 20) break;
            read_before = read2;
            @(posedge clk);
            cyc++;
         end
         check("timeout stalls", cyc, 32'd4);
         check("timeout done/err", {30'd0, cpu_done2, cpu_err2}, 32'd3);
         check("timeout read dropped", {30'd0, read_before, read2}, 32'd2);
         check("timeout rdata unchanged", cpu_rdata2, 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
